// File: rtl/approx_adder_pkg.sv
// Shared constants and per-bit cell functions for the pipelined approximate ripple-carry adder.
// Both cell functions return {cout, sum} for operand bits x, y and incoming carry z.
package approx_adder_pkg;

  localparam int DEF_WIDTH      = 16;
  localparam int DEF_STAGES     = 2;
  localparam int DEF_APPROX_MAX = 8;

  // Approximate cell: the carry out is simply the A bit, which breaks the carry chain.
  function automatic logic [1:0] approx_cell(input logic x, input logic y, input logic z);
    return {x, (~x & (y | z)) | (x & y & z)};
  endfunction

  function automatic logic [1:0] exact_cell(input logic x, input logic y, input logic z);
    return {(x & y) | (x & z) | (y & z), x ^ y ^ z};
  endfunction

endpackage

// File: rtl/approx_rc_segment.sv
// Combinational SW-bit ripple segment; mask bit i selects the approximate cell for bit i.
module approx_rc_segment
  import approx_adder_pkg::*;
#(
  parameter int SW = 8
) (
  input  logic [SW-1:0] a,
  input  logic [SW-1:0] b,
  input  logic [SW-1:0] mask,
  input  logic          cin,
  output logic [SW-1:0] sum,
  output logic          cout
);

  logic [SW:0] carry_s;
  logic [1:0]  cell_s;

  // ripple through the segment, choosing the cell type per bit
  always_comb begin
    carry_s    = '0;
    sum        = '0;
    cell_s     = 2'b00;
    carry_s[0] = cin;
    for (int i = 0; i < SW; i++) begin
      if (mask[i]) begin
        cell_s = approx_cell(a[i], b[i], carry_s[i]);
      end else begin
        cell_s = exact_cell(a[i], b[i], carry_s[i]);
      end
      sum[i]       = cell_s[0];
      carry_s[i+1] = cell_s[1];
    end
  end

  assign cout = carry_s[SW];

endmodule

// File: rtl/pipelined_approx_rc_adder.sv
// Skewed-pipeline approximate adder: one ripple segment per stage, the exact sum travels with the
// data so the last stage can flag a mismatch, plus a saturating count of erroring transfers.
module pipelined_approx_rc_adder
  import approx_adder_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int STAGES     = DEF_STAGES,
  parameter int APPROX_MAX = DEF_APPROX_MAX
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [WIDTH-1:0]                in_a,
  input  logic [WIDTH-1:0]                in_b,
  input  logic [$clog2(APPROX_MAX+1)-1:0] in_k,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [WIDTH:0]                  out_sum,
  output logic                            out_err,
  output logic [15:0]                     err_count,
  input  logic                            err_clear
);

  localparam int SW = WIDTH / STAGES;
  localparam int KW = $clog2(APPROX_MAX + 1);
  localparam logic [KW-1:0] KMAX = KW'(APPROX_MAX);

  typedef struct packed {
    logic             vld;
    logic             err;
    logic             carry;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] sum;
    logic [WIDTH:0]   exact;
  } stage_t;

  stage_t        st_r      [STAGES];
  stage_t        nxt_s     [STAGES];
  logic [SW-1:0] seg_a_s   [STAGES];
  logic [SW-1:0] seg_b_s   [STAGES];
  logic [SW-1:0] seg_m_s   [STAGES];
  logic [SW-1:0] seg_sum_s [STAGES];
  logic          seg_c_s   [STAGES];
  logic          seg_co_s  [STAGES];

  logic [KW-1:0]    k_eff_s;
  logic [WIDTH-1:0] mask_in_s;
  logic             adv_s;

  // clamp the requested approximate-cell count and expand it into a low-bit mask
  always_comb begin
    if (in_k > KMAX) begin
      k_eff_s = KMAX;
    end else begin
      k_eff_s = in_k;
    end
    mask_in_s = ~({WIDTH{1'b1}} << k_eff_s);
  end

  assign adv_s    = ~out_valid | out_ready;
  // reset forces ready so upstream never sees a stall while the pipe is being flushed
  assign in_ready = rst | adv_s;

  // route operands: segment 0 straight from the inputs, later segments from the previous stage
  always_comb begin
    for (int s = 0; s < STAGES; s++) begin
      seg_a_s[s] = '0;
      seg_b_s[s] = '0;
      seg_m_s[s] = '0;
      seg_c_s[s] = 1'b0;
    end
    seg_a_s[0] = in_a[SW-1:0];
    seg_b_s[0] = in_b[SW-1:0];
    seg_m_s[0] = mask_in_s[SW-1:0];
    seg_c_s[0] = 1'b0;
    for (int s = 1; s < STAGES; s++) begin
      seg_a_s[s] = st_r[s-1].a[s*SW +: SW];
      seg_b_s[s] = st_r[s-1].b[s*SW +: SW];
      seg_m_s[s] = st_r[s-1].mask[s*SW +: SW];
      seg_c_s[s] = st_r[s-1].carry;
    end
  end

  for (genvar g = 0; g < STAGES; g++) begin : g_seg
    approx_rc_segment #(.SW(SW)) u_seg (
      .a    (seg_a_s[g]),
      .b    (seg_b_s[g]),
      .mask (seg_m_s[g]),
      .cin  (seg_c_s[g]),
      .sum  (seg_sum_s[g]),
      .cout (seg_co_s[g])
    );
  end

  // next value of every stage register; err is only meaningful once all segments are filled in
  always_comb begin
    for (int s = 0; s < STAGES; s++) begin
      nxt_s[s] = '0;
    end
    nxt_s[0].vld          = in_valid;
    nxt_s[0].a            = in_a;
    nxt_s[0].b            = in_b;
    nxt_s[0].mask         = mask_in_s;
    nxt_s[0].exact        = {1'b0, in_a} + {1'b0, in_b};
    nxt_s[0].sum[SW-1:0]  = seg_sum_s[0];
    nxt_s[0].carry        = seg_co_s[0];
    for (int s = 1; s < STAGES; s++) begin
      nxt_s[s]                   = st_r[s-1];
      nxt_s[s].sum[s*SW +: SW]   = seg_sum_s[s];
      nxt_s[s].carry             = seg_co_s[s];
    end
    for (int s = 0; s < STAGES; s++) begin
      nxt_s[s].err = ({nxt_s[s].carry, nxt_s[s].sum} != nxt_s[s].exact);
    end
  end

  // stage registers advance together, hold on stall, and are wiped by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < STAGES; s++) begin
        st_r[s] <= '0;
      end
    end else if (adv_s) begin
      for (int s = 0; s < STAGES; s++) begin
        st_r[s] <= nxt_s[s];
      end
    end
  end

  assign out_valid = st_r[STAGES-1].vld;
  assign out_sum   = {st_r[STAGES-1].carry, st_r[STAGES-1].sum};
  assign out_err   = st_r[STAGES-1].err;

  // saturating count of erroring transfers; clear wins over a coincident increment
  always_ff @(posedge clk) begin
    if (rst) begin
      err_count <= 16'h0000;
    end else if (err_clear) begin
      err_count <= 16'h0000;
    end else if (out_valid && out_ready && out_err && (err_count != 16'hFFFF)) begin
      err_count <= err_count + 16'h0001;
    end
  end

endmodule

// File: tb/tb_pipelined_approx_rc_adder.sv
// Self-checking bench for pipelined_approx_rc_adder (16-bit, 2 stages, up to 8 approximate cells).
// Expected results come from an arithmetic reference: approximate low bits, exact add of the upper part.
module tb_pipelined_approx_rc_adder;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready, out_err, err_clear;
  logic [15:0] in_a, in_b, err_count;
  logic [3:0]  in_k;
  logic [16:0] out_sum;
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  pipelined_approx_rc_adder #(.WIDTH(16), .STAGES(2), .APPROX_MAX(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_k      (in_k),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_err   (out_err),
    .err_count (err_count),
    .err_clear (err_clear)
  );

  // Low ke bits: carry into bit i is a[i-1] (approximate cells pass A as carry).
  // Upper bits: plain addition of the shifted operands plus the carry leaving the approximate region.
  function automatic logic [16:0] ref_sum(input logic [15:0] a, input logic [15:0] b, input int k);
    int          ke;
    logic [16:0] up;
    logic [16:0] lo;
    logic        c;
    logic        cin;
    ke = (k > 8) ? 8 : k;
    lo = 17'd0;
    for (int i = 0; i < ke; i++) begin
      c     = (i == 0) ? 1'b0 : a[i-1];
      lo[i] = (~a[i] & (b[i] | c)) | (a[i] & b[i] & c);
    end
    cin = (ke == 0) ? 1'b0 : a[ke-1];
    up  = ({1'b0, a} >> ke) + ({1'b0, b} >> ke) + {16'd0, cin};
    return (up << ke) | lo;
  endfunction

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_a = 16'h1234; in_b = 16'h4321; in_k = 4'd3;
    out_ready = 1'b0; err_clear = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    repeat (2) @(posedge clk);
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    total++; if (out_sum !== 17'h0) begin bad++; $display("FAIL reset_out_sum: got %h want 0", out_sum); end
    total++; if (out_err !== 1'b0) begin bad++; $display("FAIL reset_out_err: got %b want 0", out_err); end
    total++; if (err_count !== 16'h0) begin bad++; $display("FAIL reset_err_count: got %h want 0", err_count); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready_held: got %b want 1", in_ready); end
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_no_accept: got %b want 0", out_valid); end
  endtask

  task automatic test_directed();
    logic [15:0] da [4] = '{16'h00FF, 16'h0001, 16'hFFFF, 16'h0001};
    logic [15:0] db [4] = '{16'h0001, 16'h0000, 16'h0001, 16'h0000};
    logic [3:0]  dk [4] = '{4'd8, 4'd8, 4'd0, 4'd15};
    logic [16:0] ds [4] = '{17'h00100, 17'h00002, 17'h10000, 17'h00002};
    logic        de [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [15:0] dc [4] = '{16'd0, 16'd1, 16'd1, 16'd2};
    for (int t = 0; t < 4; t++) begin
      in_valid = 1'b1; in_a = da[t]; in_b = db[t]; in_k = dk[t]; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL dir%0d_latency_early: got %b want 0", t, out_valid); end
      @(posedge clk); #1;
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL dir%0d_latency: got %b want 1", t, out_valid); end
      total++; if (out_sum !== ds[t]) begin bad++; $display("FAIL dir%0d_sum: got %h want %h", t, out_sum, ds[t]); end
      total++; if (out_err !== de[t]) begin bad++; $display("FAIL dir%0d_err: got %b want %b", t, out_err, de[t]); end
      @(posedge clk); #1;
      total++; if (err_count !== dc[t]) begin bad++; $display("FAIL dir%0d_err_count: got %0d want %0d", t, err_count, dc[t]); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL dir%0d_no_dup: got %b want 0", t, out_valid); end
    end
  endtask

  // patterned: out_ready cycles 1,0,0,1 with continuous input; otherwise random valid/ready
  task automatic test_stream(input int ntx, input bit patterned);
    logic [17:0] q[$];
    logic [17:0] exp_v;
    logic [16:0] ps;
    logic [16:0] rs;
    logic        pv, pr, pe, iv, ordy, exp_rdy;
    int          sent, got, cyc;
    int          pat [4] = '{1, 0, 0, 1};
    sent = 0; got = 0; cyc = 0; pv = 1'b0; pr = 1'b1; ps = 17'h0; pe = 1'b0;
    while ((sent < ntx || got < sent) && cyc < 5000) begin
      if (pv && !pr) begin
        total++;
        if (out_valid !== 1'b1 || out_sum !== ps || out_err !== pe) begin
          bad++; $display("FAIL stall_stable: got v=%b s=%h e=%b want v=1 s=%h e=%b", out_valid, out_sum, out_err, ps, pe);
        end
      end
      iv   = (sent < ntx) && (patterned || ($urandom_range(0, 3) != 0));
      ordy = patterned ? (pat[cyc % 4] != 0) : ($urandom_range(0, 2) != 0);
      in_valid = iv; out_ready = ordy;
      in_a = 16'($urandom); in_b = 16'($urandom); in_k = 4'($urandom_range(0, 15));
      #1;
      exp_rdy = ~out_valid | ordy;
      total++; if (in_ready !== exp_rdy) begin bad++; $display("FAIL stream_in_ready: got %b want %b", in_ready, exp_rdy); end
      if (iv && exp_rdy) begin
        rs = ref_sum(in_a, in_b, int'(in_k));
        q.push_back({(rs != ({1'b0, in_a} + {1'b0, in_b})), rs});
        sent++;
      end
      if (out_valid === 1'b1 && ordy) begin
        total++;
        if (q.size() == 0) begin
          bad++; $display("FAIL stream_extra: got s=%h with nothing expected", out_sum);
        end else begin
          exp_v = q.pop_front();
          if (out_sum !== exp_v[16:0] || out_err !== exp_v[17]) begin
            bad++; $display("FAIL stream_data: got s=%h e=%b want s=%h e=%b", out_sum, out_err, exp_v[16:0], exp_v[17]);
          end
        end
        got++;
      end
      pv = out_valid; pr = ordy; ps = out_sum; pe = out_err;
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    total++;
    if (got != ntx || q.size() != 0) begin
      bad++; $display("FAIL stream_count: got %0d results want %0d", got, ntx);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_saturate();
    int xfers, cyc;
    xfers = 0; cyc = 0;
    in_valid = 1'b1; in_a = 16'h0001; in_b = 16'h0000; in_k = 4'd8; out_ready = 1'b1; err_clear = 1'b0;
    while (xfers < 70000 && cyc < 71000) begin
      if (out_valid === 1'b1) xfers++;
      @(posedge clk); #1;
      cyc++;
    end
    total++; if (xfers != 70000) begin bad++; $display("FAIL sat_budget: got %0d transfers want 70000", xfers); end
    total++; if (err_count !== 16'hFFFF) begin bad++; $display("FAIL sat_count: got %h want ffff", err_count); end
    total++;
    if (out_valid !== 1'b1 || out_err !== 1'b1) begin
      bad++; $display("FAIL sat_pre_clear: got v=%b e=%b want v=1 e=1", out_valid, out_err);
    end
    in_valid = 1'b0; err_clear = 1'b1;
    @(posedge clk); #1;
    total++; if (err_count !== 16'h0) begin bad++; $display("FAIL clear_priority: got %h want 0", err_count); end
    err_clear = 1'b0;
    @(posedge clk); #1;
    total++; if (err_count !== 16'h1) begin bad++; $display("FAIL count_after_clear: got %h want 1", err_count); end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_inflight();
    in_valid = 1'b1; in_a = 16'h0001; in_b = 16'h0000; in_k = 4'd8; out_ready = 1'b1;
    @(posedge clk); #1;
    in_a = 16'h0003;
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL inflight_pre: got %b want 1", out_valid); end
    rst = 1'b1; out_ready = 1'b0; in_a = 16'h0101;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL inflight_rst_ready: got %b want 1", in_ready); end
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL inflight_valid: got %b want 0", out_valid); end
    total++; if (err_count !== 16'h0) begin bad++; $display("FAIL inflight_count: got %h want 0", err_count); end
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL inflight_stale%0d: got %b want 0", c, out_valid); end
      @(posedge clk); #1;
    end
    total++; if (err_count !== 16'h0) begin bad++; $display("FAIL inflight_count_end: got %h want 0", err_count); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stream(8, 1'b1);
    test_stream(300, 1'b0);
    test_saturate();
    test_reset_inflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/pipelined_approx_rc_adder.md
PIPELINED_APPROX_RC_ADDER -- requirements
Module: pipelined_approx_rc_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand width in bits; legal range 4..64.
REQ-002 SHALL have parameter STAGES, default 2: number of pipeline segments; WIDTH mod STAGES == 0.
REQ-003 SHALL have parameter APPROX_MAX, default 8: maximum number of approximate LSB cells; APPROX_MAX <= WIDTH.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port in_valid, input, 1 bit: operands present.
REQ-007 SHALL have port in_ready, output, 1 bit: pipeline accepts an operand set this cycle.
REQ-008 SHALL have port in_a, input, WIDTH bits: operand A.
REQ-009 SHALL have port in_b, input, WIDTH bits: operand B.
REQ-010 SHALL have port in_k, input, clog2(APPROX_MAX+1) bits: approximate-cell count for this transaction.
REQ-011 SHALL have port out_valid, output, 1 bit: result present.
REQ-012 SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-013 SHALL have port out_sum, output, WIDTH+1 bits: approximate sum, with the MSB being the final carry.
REQ-014 SHALL have port out_err, output, 1 bit: out_sum differs from the exact in_a+in_b.
REQ-015 SHALL have port err_count, output, 16 bits: saturating count of transferred results with out_err=1.
REQ-016 SHALL have port err_clear, input, 1 bit: zero err_count.

Function
REQ-017 SHALL implement bit i as an approximate cell when i < k_eff, and as an exact full adder otherwise, where k_eff = min(in_k, APPROX_MAX) captured with the transaction.
REQ-018 SHALL define the approximate cell as Cout = X and S = (~X & (Y | Z)) | (X & Y & Z); the exact cell is S = X^Y^Z and Cout = majority(X, Y, Z).
REQ-019 SHALL use a carry-in of 0 into bit 0.
REQ-020 SHALL make segment s process bits [s*W/S +: W/S]; the inter-segment carry, the upper operand bits and the lower result bits SHALL be registered per stage (skewed pipeline).
REQ-021 SHALL have a latency of exactly STAGES cycles from an accepted input to out_valid when out_ready is held at 1.
REQ-022 SHALL define the transfer rule: an input is accepted when in_valid & in_ready; an output is transferred when out_valid & out_ready.
REQ-023 SHALL drive in_ready = ~out_valid | out_ready; all stage registers advance together on in_ready, and SHALL hold their contents otherwise.
REQ-024 SHALL insert a bubble (stage valid = 0) when in_valid = 0 while the pipeline advances.
REQ-025 SHALL carry the exact sum alongside the data, so that out_err = (out_sum != exact WIDTH+1-bit sum).
REQ-026 SHALL increment err_count on each transfer with out_err = 1, saturating at 0xFFFF.
REQ-027 SHALL give err_clear priority when err_clear and an erroring transfer coincide: the count becomes 0.
REQ-028 SHALL hold out_sum, out_err and out_valid stable while out_valid & ~out_ready.
REQ-029 SHALL allow back-to-back transactions with differing in_k, each result using its own k_eff.

Reset
REQ-030 SHALL, when rst = 1 at a clock edge, clear all stage valids, out_valid, out_sum, out_err and err_count to 0; in-flight data SHALL be discarded.
REQ-031 SHALL hold in_ready = 1 during and after reset, and SHALL accept no input on a cycle where rst = 1.

Structure
REQ-032 SHALL place the default parameter constants and the approximate-cell truth function in a shared package approx_adder_pkg.
REQ-033 SHALL use one sub-module, approx_rc_segment: a combinational W/S-bit ripple segment taking its per-bit approximate mask and carry-in.

Verification (WIDTH=16, STAGES=2, APPROX_MAX=8)
REQ-034 SHALL test a=0x00FF, b=0x0001, k=8 -> out_sum=0x00100, out_err=0, two cycles after acceptance.
REQ-035 SHALL test a=0x0001, b=0x0000, k=8 -> out_sum=0x00002, out_err=1, err_count=1.
REQ-036 SHALL test a=0xFFFF, b=0x0001, k=0 -> out_sum=0x10000, out_err=0.
REQ-037 SHALL test an 8-transaction stream while out_ready toggles 1,0,0,1 -> no loss or duplication, order preserved, and outputs stable while stalled.
REQ-038 SHALL test 70000 erroring transfers -> err_count=0xFFFF; a following err_clear coinciding with an erroring transfer -> err_count=0.
REQ-039 SHALL test rst asserted with 2 transactions in flight -> out_valid=0 on the next cycle, no stale results, err_count=0.
